// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: skid-buffer state encoding
// and the layout of the {N,Z,C,V} flags nibble.
package alu_pkg;

  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // EMPTY: no entry held; ONE: main holds the head; FULL: main and skid both hold.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generator: N and Z derived from the result value,
// C and V passed straight through from the upstream operation.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] result,
  input  logic                 carry,
  input  logic                 overflow,
  output logic [FLAG_W-1:0]    flags
);

  // Assemble {N,Z,C,V} from the result and upstream status bits.
  always_comb begin
    flags         = {FLAG_W{1'b0}};
    flags[FLAG_N] = result[BUS_WIDTH-1];
    flags[FLAG_Z] = (result == {BUS_WIDTH{1'b0}});
    flags[FLAG_C] = carry;
    flags[FLAG_V] = overflow;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: two-entry skid buffer (main + skid) with
// valid/ready on both sides, capture-time flag generation and the
// architectural flags register updated when a flag-writing result is consumed.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_result,
  input  logic                 in_carry,
  input  logic                 in_overflow,
  input  logic                 in_flags_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic [FLAG_W-1:0]    out_flags,
  output logic [FLAG_W-1:0]    flags_q
);

  stage_state_t         state;
  stage_state_t         next_state;

  logic [BUS_WIDTH-1:0] main_result;
  logic [FLAG_W-1:0]    main_flags;
  logic                 main_we;
  logic [BUS_WIDTH-1:0] skid_result;
  logic [FLAG_W-1:0]    skid_flags;
  logic                 skid_we;

  logic [FLAG_W-1:0]    in_flags;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  alu_flag_gen #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_flag_gen (
    .result   (in_result),
    .carry    (in_carry),
    .overflow (in_overflow),
    .flags    (in_flags)
  );

  // Handshake decode: both ready and valid come only from the state register,
  // so out_ready never reaches in_ready combinationally.
  assign in_ready   = (state != ST_FULL);
  assign out_valid  = (state != ST_EMPTY);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_result = main_result;
  assign out_flags  = main_flags;

  // Next-state and entry-load selection for the skid buffer.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          next_state   = ST_ONE;
        end else begin
          next_state   = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
          next_state   = ST_ONE;
        end else if (in_fire) begin
          load_skid    = 1'b1;
          next_state   = ST_FULL;
        end else if (out_fire) begin
          next_state   = ST_EMPTY;
        end else begin
          next_state   = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          next_state     = ST_ONE;
        end else begin
          next_state     = ST_FULL;
        end
      end
      default: begin
        next_state = ST_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Main entry: loaded from the input or promoted from the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result <= {BUS_WIDTH{1'b0}};
      main_flags  <= {FLAG_W{1'b0}};
      main_we     <= 1'b0;
    end else if (load_main_in) begin
      main_result <= in_result;
      main_flags  <= in_flags;
      main_we     <= in_flags_we;
    end else if (load_main_skid) begin
      main_result <= skid_result;
      main_flags  <= skid_flags;
      main_we     <= skid_we;
    end
  end

  // Skid entry: catches the input while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result <= {BUS_WIDTH{1'b0}};
      skid_flags  <= {FLAG_W{1'b0}};
      skid_we     <= 1'b0;
    end else if (load_skid) begin
      skid_result <= in_result;
      skid_flags  <= in_flags;
      skid_we     <= in_flags_we;
    end
  end

  // Architectural flags: updated only when a flag-writing head is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= {FLAG_W{1'b0}};
    end else if (out_fire && main_we) begin
      flags_q <= main_flags;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_overflow;
  logic       in_flags_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] flags_q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    bit         we;
  } ent_t;

  ent_t       model_q[$];
  logic [3:0] model_flags;

  alu_result_stage #(.BUS_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_flags_we (in_flags_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .flags_q     (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_flags(input logic [7:0] r, input bit c, input bit v);
    bit n;
    bit z;
    n = (r >= 8'd128);
    z = (r == 8'd0);
    return {n, z, c, v};
  endfunction

  // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic cycle(input bit iv, input logic [7:0] d, input bit c, input bit v,
                       input bit we, input bit ordy);
    bit   exp_valid;
    bit   exp_ready;
    bit   in_f;
    bit   out_f;
    ent_t e;
    in_valid    = iv;
    in_result   = d;
    in_carry    = c;
    in_overflow = v;
    in_flags_we = we;
    out_ready   = ordy;
    @(negedge clk);
    exp_valid = (model_q.size() > 0);
    exp_ready = (model_q.size() < 2);
    check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("flags_q", 32'(flags_q), 32'(model_flags));
    if (exp_valid) begin
      check_eq("out_result", 32'(out_result), 32'(model_q[0].res));
      check_eq("out_flags", 32'(out_flags), 32'(model_q[0].fl));
    end
    in_f  = iv && exp_ready;
    out_f = exp_valid && ordy;
    @(posedge clk);
    if (out_f) begin
      e = model_q.pop_front();
      if (e.we) model_flags = e.fl;
    end
    if (in_f) begin
      e.res = d;
      e.fl  = ref_flags(d, c, v);
      e.we  = we;
      model_q.push_back(e);
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_result"}, 32'(out_result), 32'd0);
    check_eq({tag, "_oflags"}, 32'(out_flags), 32'd0);
    check_eq({tag, "_flagsq"}, 32'(flags_q), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_result   = 8'h00;
    in_carry    = 1'b0;
    in_overflow = 1'b0;
    in_flags_we = 1'b0;
    out_ready   = 1'b0;
    model_flags = 4'b0000;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single transfer, captured on the first edge after release.
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("single_oflags", 32'(out_flags), 32'h6);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("single_flagsq", 32'(flags_q), 32'h6);

    // Back-pressure: two captures fill the buffer, then drain in order.
    cycle(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bp_full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bp_head", 32'(out_result), 32'hF0);
    check_eq("bp_head_fl", 32'(out_flags), 32'h8);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("bp_second", 32'(out_result), 32'h0F);
    check_eq("bp_second_fl", 32'(out_flags), 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i + 8'h30), i[0], i[1], 1'b1, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flags write-enable: a non-writing result leaves flags_q alone.
    cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("we0_flagsq", 32'(flags_q), 32'(model_flags));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("we1_flagsq", 32'(flags_q), 32'h4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) < 6));
    end

    // Reset mid-operation from FULL.
    cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_q.delete();
    model_flags = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cycle(1'b1, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
